// File: rtl/conv_pkg.sv
// Shared defaults and FSM state type for the sliding-window generator.
package conv_pkg;
  localparam int IMG_W  = 27;
  localparam int IMG_H  = 27;
  localparam int K      = 3;
  localparam int DATA_W = 8;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } win_state_t;
endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: the word read at the pointer is the one written DEPTH accepts ago.
module conv_line_buffer #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int DEPTH  = conv_pkg::IMG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
    end else if (i_en) begin
      r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
    end
  end

  // Read-before-write at the same address gives the full-row delay.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  assign o_dout = r_mem[r_wptr];
endmodule

// File: rtl/conv_window_gen.sv
// Raster-order KxK sliding-window generator with FWFT input and valid/ready output.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = conv_pkg::IMG_W,
  parameter int IMG_H  = conv_pkg::IMG_H,
  parameter int K      = conv_pkg::K,
  parameter int DATA_W = conv_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in_feature,
  input  logic                    in_valid,
  output logic                    rd_en,
  output logic [K*K*DATA_W-1:0]   out_window,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FILL  = RW'(K - 2);

  logic                  w_accept;
  logic                  w_emit;
  logic                  w_col_last;
  logic                  w_row_last;
  logic [DATA_W-1:0]     w_lb_dout [K-1];
  logic [DATA_W-1:0]     w_win_nxt [K][K];
  logic [K*K*DATA_W-1:0] w_win_flat;

  logic [DATA_W-1:0]     r_win [K][K];
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  win_state_t            r_state;
  logic                  r_out_valid;
  logic                  r_frame_done;
  logic [K*K*DATA_W-1:0] r_out_window;

  assign rd_en      = in_valid && (!r_out_valid || out_ready);
  assign w_accept   = rd_en;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  // STREAM already implies row >= K-1; the column test keeps windows inside one row.
  assign w_emit     = w_accept && (r_state == STREAM) && (r_col >= COL_FIRST);

  // Line buffer 0 holds the oldest row; K-2 is fed directly by the incoming pixel.
  for (genvar g = 0; g < K - 1; g++) begin : g_lb
    logic [DATA_W-1:0] w_din;
    if (g == K - 2) begin : g_newest
      assign w_din = in_feature;
    end else begin : g_cascade
      assign w_din = w_lb_dout[g+1];
    end
    conv_line_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W)
    ) u_lb (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_accept),
      .i_din  (w_din),
      .o_dout (w_lb_dout[g])
    );
  end

  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        w_win_nxt[i][j] = r_win[i][j+1];
      end
    end
    for (int i = 0; i < K - 1; i++) begin
      w_win_nxt[i][K-1] = w_lb_dout[i];
    end
    w_win_nxt[K-1][K-1] = in_feature;
  end

  always_comb begin
    w_win_flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        w_win_flat[(i*K+j)*DATA_W +: DATA_W] = w_win_nxt[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_win <= w_win_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_state      <= FILL;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_out_window <= '0;
    end else if (w_accept) begin
      r_col <= w_col_last ? '0 : r_col + 1'b1;
      if (w_col_last) begin
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end
      case (r_state)
        FILL:    if (w_col_last && (r_row == ROW_FILL)) r_state <= STREAM;
        STREAM:  if (w_col_last && w_row_last) r_state <= FILL;
        default: r_state <= FILL;
      endcase
      // An accept implies any pending window is being consumed this edge.
      r_out_valid  <= w_emit;
      r_frame_done <= w_emit && w_col_last && w_row_last;
      if (w_emit) begin
        r_out_window <= w_win_flat;
      end
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end
  end

  assign out_window = r_out_window;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;
endmodule
